// File: rtl/up_down_counter_param.sv
// up_down_counter_param
// Parameterised up/down counter with a programmable terminal count.
// Wrap or saturate at the terminal values. Registered one-cycle ovf/unf
// pulses mark each terminal event. Clear and load take priority over counting.
module up_down_counter_param #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir_up,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // A load above the terminal count is clamped so that count never leaves 0..MAX_VAL.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // This is the value after an up-count from MAX_VAL: hold in saturate mode, wrap to zero otherwise.
    function automatic logic [WIDTH-1:0] up_terminal_next();
        return (SATURATE != 0) ? MAX_VAL : ZERO;
    endfunction

    // This is the value after a down-count from zero: hold in saturate mode, wrap to MAX_VAL otherwise.
    function automatic logic [WIDTH-1:0] down_terminal_next();
        return (SATURATE != 0) ? ZERO : MAX_VAL;
    endfunction

    // Next-state selection with priority sync_clr > load > en > hold.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (sync_clr) begin
            count_nxt = ZERO;
        end else if (load) begin
            count_nxt = clamp_to_max(load_val);
        end else if (en) begin
            if (dir_up) begin
                if (count == MAX_VAL) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = up_terminal_next();
                end else begin
                    count_nxt = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    unf_nxt   = 1'b1;
                    count_nxt = down_terminal_next();
                end else begin
                    count_nxt = count - ONE;
                end
            end
        end
    end

    // Counter and event-pulse registers; clear_n resets them at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count <= ZERO;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == ZERO);

endmodule

// File: tb/tb_up_down_counter_param.sv
// Testbench for up_down_counter_param.
// Three instances share the stimulus:
//   - WIDTH=4, MAX=9, wrap
//   - WIDTH=4, MAX=9, saturate
//   - WIDTH=2, MAX=1, wrap
// Expected results go into per-instance queues when stimulus is driven.
// They are popped and compared after the active clock edge.
module tb_up_down_counter_param;

    logic       clk;
    logic       clear_n;
    logic       sync_clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       dir_up;

    logic [3:0] cnt_w, cnt_s;
    logic [1:0] cnt_t;
    logic       amax_w, amin_w, ovf_w, unf_w;
    logic       amax_s, amin_s, ovf_s, unf_s;
    logic       amax_t, amin_t, ovf_t, unf_t;

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
        bit amax;
        bit amin;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    exp_t q_t[$];

    int m_w, m_s, m_t;
    int n_asserts = 0;
    int n_fail    = 0;

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) dut_w (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load),
        .load_val(load_val), .en(en), .dir_up(dir_up), .count(cnt_w),
        .at_max(amax_w), .at_min(amin_w), .ovf(ovf_w), .unf(unf_w));

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) dut_s (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load),
        .load_val(load_val), .en(en), .dir_up(dir_up), .count(cnt_s),
        .at_max(amax_s), .at_min(amin_s), .ovf(ovf_s), .unf(unf_s));

    up_down_counter_param #(.WIDTH(2), .MAX_VAL(2'd1), .SATURATE(0)) dut_t (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load),
        .load_val(load_val[1:0]), .en(en), .dir_up(dir_up), .count(cnt_t),
        .at_max(amax_t), .at_min(amin_t), .ovf(ovf_t), .unf(unf_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour of one counter for one clock edge.
    task automatic predict(input int mx, input bit sat, input int lv, input bit sc,
                           input bit ld, input bit e, input bit d,
                           inout int m, output exp_t x);
        x.ovf = 1'b0;
        x.unf = 1'b0;
        if (sc)
            x.cnt = 0;
        else if (ld)
            x.cnt = (lv > mx) ? mx : lv;
        else if (e && d) begin
            x.ovf = (m == mx);
            x.cnt = (m + 1 > mx) ? (sat ? mx : 0) : m + 1;
        end else if (e && !d) begin
            x.unf = (m == 0);
            x.cnt = (m - 1 < 0) ? (sat ? 0 : mx) : m - 1;
        end else
            x.cnt = m;
        x.amax = (x.cnt == mx);
        x.amin = (x.cnt == 0);
        m = x.cnt;
    endtask

    task automatic cmp(input string tag, input exp_t x, input logic [31:0] c,
                       input logic o, input logic u, input logic amx, input logic amn);
        check({tag, ".count"}, c, x.cnt);
        check({tag, ".ovf"}, {31'd0, o}, {31'd0, x.ovf});
        check({tag, ".unf"}, {31'd0, u}, {31'd0, x.unf});
        check({tag, ".at_max"}, {31'd0, amx}, {31'd0, x.amax});
        check({tag, ".at_min"}, {31'd0, amn}, {31'd0, x.amin});
        check({tag, ".ovf_and_unf"}, {31'd0, o & u}, 32'd0);
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t x;
        x = q_w.pop_front();
        cmp({tag, ".w"}, x, {28'd0, cnt_w}, ovf_w, unf_w, amax_w, amin_w);
        x = q_s.pop_front();
        cmp({tag, ".s"}, x, {28'd0, cnt_s}, ovf_s, unf_s, amax_s, amin_s);
        x = q_t.pop_front();
        cmp({tag, ".t"}, x, {30'd0, cnt_t}, ovf_t, unf_t, amax_t, amin_t);
    endtask

    // Drive one cycle of stimulus, queue the predictions, clock, then compare.
    task automatic step(input string tag, input bit sc, input bit ld,
                        input logic [3:0] lv, input bit e, input bit d);
        exp_t x;
        sync_clr = sc;
        load     = ld;
        load_val = lv;
        en       = e;
        dir_up   = d;
        predict(9, 1'b0, int'(lv), sc, ld, e, d, m_w, x);
        q_w.push_back(x);
        predict(9, 1'b1, int'(lv), sc, ld, e, d, m_s, x);
        q_s.push_back(x);
        predict(1, 1'b0, int'(lv[1:0]), sc, ld, e, d, m_t, x);
        q_t.push_back(x);
        @(posedge clk);
        #1;
        pop_and_compare(tag);
        sync_clr = 1'b0;
        load     = 1'b0;
    endtask

    // Expected state while or right after clear_n is asserted.
    task automatic reset_expect(input string tag);
        exp_t x;
        x.cnt  = 0;
        x.ovf  = 1'b0;
        x.unf  = 1'b0;
        x.amax = 1'b0;
        x.amin = 1'b1;
        m_w = 0;
        m_s = 0;
        m_t = 0;
        q_w.push_back(x);
        q_s.push_back(x);
        q_t.push_back(x);
        pop_and_compare(tag);
    endtask

    initial begin
        clear_n  = 1'b0;
        sync_clr = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b0;
        dir_up   = 1'b0;
        m_w = 0;
        m_s = 0;
        m_t = 0;

        // Reset state, including an enabled edge while clear_n is held low.
        repeat (2) @(posedge clk);
        en = 1'b1;
        dir_up = 1'b1;
        @(posedge clk);
        #1;
        reset_expect("reset");
        #3;
        clear_n = 1'b1;

        // Wrap up from 0 for 10 edges: 0..9 then back to 0 with ovf.
        for (int i = 0; i < 10; i++) step($sformatf("up%0d", i), 0, 0, 4'd0, 1, 1);
        check("wrap_up.count_zero", {28'd0, cnt_w}, 32'd0);
        check("wrap_up.ovf_pulse", {31'd0, ovf_w}, 32'd1);
        step("up_after", 0, 0, 4'd0, 1, 0);
        check("wrap_up.ovf_dropped", {31'd0, ovf_w}, 32'd0);

        // Wrap down: clear, then 0 -> 9 with unf, then 8, 7.
        step("clr", 1, 0, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("down%0d", i), 0, 0, 4'd0, 1, 0);
        check("wrap_down.count_7", {28'd0, cnt_w}, 32'd7);

        // Saturate: load 9 (no pulse on the load edge), then three up edges.
        step("load9", 0, 1, 4'd9, 1, 1);
        check("sat.load_no_ovf", {31'd0, ovf_s}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sat_up%0d", i), 0, 0, 4'd0, 1, 1);
            check($sformatf("sat.ovf_held%0d", i), {31'd0, ovf_s}, 32'd1);
            check($sformatf("sat.count9_%0d", i), {28'd0, cnt_s}, 32'd9);
        end

        // Saturate at zero: consecutive unf pulses.
        step("clr2", 1, 0, 4'd0, 1, 0);
        step("sat_dn0", 0, 0, 4'd0, 1, 0);
        step("sat_dn1", 0, 0, 4'd0, 1, 0);
        check("sat.unf_held", {31'd0, unf_s}, 32'd1);

        // Priority and clamp.
        step("load3", 0, 1, 4'd3, 0, 0);
        step("prio", 1, 1, 4'd5, 1, 1);
        check("prio.count_zero", {28'd0, cnt_w}, 32'd0);
        step("clamp", 0, 1, 4'd15, 1, 1);
        check("clamp.count_9", {28'd0, cnt_w}, 32'd9);
        step("load_at_max", 0, 1, 4'd9, 1, 1);

        // Asynchronous reset between edges while count = 5.
        step("load5", 0, 1, 4'd5, 0, 1);
        en = 1'b1;
        dir_up = 1'b1;
        #3;
        clear_n = 1'b0;
        #1;
        reset_expect("async_mid");
        @(posedge clk);
        #1;
        reset_expect("async_held");
        #3;
        clear_n = 1'b1;
        step("resume", 0, 0, 4'd0, 1, 1);
        check("resume.count_1", {28'd0, cnt_w}, 32'd1);

        // Hold: en=0 with dir_up toggling at count 4.
        step("load4", 0, 1, 4'd4, 0, 0);
        for (int i = 0; i < 5; i++) step($sformatf("hold%0d", i), 0, 0, 4'd0, 0, i[0]);
        check("hold.count_4", {28'd0, cnt_w}, 32'd4);

        // Mixed stimulus.
        for (int i = 0; i < 40; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
